// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and forwarding controller for the in-order pipeline.
// It keeps a scoreboard of the instructions between EX (slot 0) and WB
// (slot DEPTH-1). From it, it derives PC/IF-ID stalls, flushes and one-hot
// forward selects. A taken branch in EX overrides any data stall.
// Build option: define HZ_FWD_EN when the forwarding datapath exists. With it,
// only a load-use hazard stalls. Without it, any RAW match stalls and the
// forward selects are tied to zero.
module hazard_ctrl #(
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic             id_we,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [DEPTH-1:0] fwd_rs1_sel,
  output logic [DEPTH-1:0] fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  // scoreboard slots: slot 0 = EX ... slot DEPTH-1 = WB
  logic [DEPTH-1:0]         s_v, s_we, s_ld;
  logic [DEPTH-1:0][AW-1:0] s_rd;

  logic [DEPTH-1:0] m1, m2;
  logic             ld_hz, hz, stall;

  // per-slot RAW match for each source operand; x0 and an idle ID never match
  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      m1[k] = id_valid & id_re1 & (id_rs1 != '0) & s_v[k] & s_we[k] & (s_rd[k] == id_rs1);
      m2[k] = id_valid & id_re2 & (id_rs2 != '0) & s_v[k] & s_we[k] & (s_rd[k] == id_rs2);
    end
  end

  // load-use: the producer in EX is a load, so its data is not ready yet
  assign ld_hz = |((m1 | m2) & s_ld & DEPTH'(1));

`ifdef HZ_FWD_EN
  assign hz = ld_hz;
`else
  // without forwarding every in-flight producer blocks the consumer
  assign hz = (|(m1 | m2)) | ld_hz;
`endif

  // effective data stall: a branch squashes the consumer, reset clears all
  assign stall = hz & ~ex_br_taken & ~rst;

  // stall / flush outputs; branch flush wins over a data stall
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst) begin
      if (ex_br_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (hz) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  // forward selects: lowest (youngest) matching slot wins, one-hot
  always_comb begin
    fwd_rs1_sel = '0;
    fwd_rs2_sel = '0;
`ifdef HZ_FWD_EN
    if (!rst && !stall) begin
      fwd_rs1_sel = m1 & (~m1 + DEPTH'(1));
      fwd_rs2_sel = m2 & (~m2 + DEPTH'(1));
    end
`endif
  end

  // scoreboard shift; a stalled or squashed ID instruction enters as a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      s_v  <= '0;
      s_we <= '0;
      s_ld <= '0;
      s_rd <= '0;
    end else begin
      for (int k = DEPTH-1; k > 0; k--) begin
        s_v[k]  <= s_v[k-1];
        s_we[k] <= s_we[k-1];
        s_ld[k] <= s_ld[k-1];
        s_rd[k] <= s_rd[k-1];
      end
      s_v[0]  <= id_valid & ~stall & ~ex_br_taken;
      s_we[0] <= id_we;
      s_ld[0] <= id_is_load;
      s_rd[0] <= id_rd;
    end
  end

  // saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (pc_stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl (DEPTH=3) in whichever
// HZ_FWD_EN configuration the design is built with.
module tb_hazard_ctrl;
  localparam int DEPTH = 3;
  localparam int AW    = 5;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_re1, id_re2, id_we, id_is_load, ex_br_taken;
  logic [AW-1:0]    id_rs1, id_rs2, id_rd;
  logic             pc_stall, if_id_stall, if_id_flush, id_ex_flush;
  logic [DEPTH-1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic [CNT_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_re1(id_re1), .id_re2(id_re2), .id_we(id_we), .id_rd(id_rd),
    .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive the ID/EX inputs
  task automatic put(input int v, input int rs1, input int re1, input int rs2, input int re2,
                     input int we, input int rd, input int ld, input int br);
    id_valid    = 1'(v);
    id_rs1      = AW'(rs1);
    id_re1      = 1'(re1);
    id_rs2      = AW'(rs2);
    id_re2      = 1'(re2);
    id_we       = 1'(we);
    id_rd       = AW'(rd);
    id_is_load  = 1'(ld);
    ex_br_taken = 1'(br);
  endtask

  task automatic idle();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // advance to the next falling edge, then apply new inputs
  task automatic cyc();
    @(negedge clk);
  endtask

  // compare all combinational outputs; if_id_stall always mirrors pc_stall
  task automatic outs(input string tag, input logic pc, input logic fl_if, input logic fl_ex,
                      input logic [DEPTH-1:0] f1, input logic [DEPTH-1:0] f2);
    #1;
    chk({tag, ".pc_stall"},    32'(pc_stall),    32'(pc));
    chk({tag, ".if_id_stall"}, 32'(if_id_stall), 32'(pc));
    chk({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(fl_if));
    chk({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'(fl_ex));
    chk({tag, ".fwd1"},        32'(fwd_rs1_sel), 32'(f1));
    chk({tag, ".fwd2"},        32'(fwd_rs2_sel), 32'(f2));
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // reset with hostile inputs: every output except the counter reads 0
    rst = 1'b1;
    put(1, 5, 1, 5, 1, 1, 5, 1, 1);
    outs("rst_comb", 0, 0, 0, 3'b000, 3'b000);
    cyc();
    rst = 1'b0;
    idle();
    outs("post_rst", 0, 0, 0, 3'b000, 3'b000);
    chk("post_rst.cnt", stall_cnt, 0);

    // A: add x5 ; add x6,x5,x1
    cyc(); put(1, 1, 1, 2, 1, 1, 5, 0, 0);
    outs("A.prod", 0, 0, 0, 3'b000, 3'b000);
    cyc(); put(1, 5, 1, 1, 1, 1, 6, 0, 0);
`ifdef HZ_FWD_EN
    outs("A.cons", 0, 0, 0, 3'b001, 3'b000);
    cyc(); idle();
    outs("A.idle", 0, 0, 0, 3'b000, 3'b000);
    chk("A.cnt", stall_cnt, 0);
`else
    for (int i = 0; i < DEPTH; i++) begin
      outs("A.stall", 1, 0, 1, 3'b000, 3'b000);
      cyc();
    end
    outs("A.release", 0, 0, 0, 3'b000, 3'b000);
    chk("A.cnt", stall_cnt, 3);
`endif

    // B: lw x5 ; add x6,x0,x5
    do_reset();
    put(1, 1, 1, 0, 0, 1, 5, 1, 0);
    outs("B.load", 0, 0, 0, 3'b000, 3'b000);
    chk("B.cnt0", stall_cnt, 0);
    cyc(); put(1, 0, 1, 5, 1, 1, 6, 0, 0);
`ifdef HZ_FWD_EN
    outs("B.stall", 1, 0, 1, 3'b000, 3'b000);
    cyc();
    outs("B.fwd", 0, 0, 0, 3'b000, 3'b010);
    chk("B.cnt", stall_cnt, 1);
`else
    for (int i = 0; i < DEPTH; i++) begin
      outs("B.stall", 1, 0, 1, 3'b000, 3'b000);
      cyc();
    end
    outs("B.release", 0, 0, 0, 3'b000, 3'b000);
    chk("B.cnt", stall_cnt, 3);
`endif

    // C: load-use hazard coinciding with a taken branch -> flush only
    do_reset();
    put(1, 1, 1, 0, 0, 1, 5, 1, 0);
    cyc(); put(1, 5, 1, 5, 1, 1, 6, 0, 1);
    #1;
    chk("C.pc_stall",    32'(pc_stall),    0);
    chk("C.if_id_stall", 32'(if_id_stall), 0);
    chk("C.if_id_flush", 32'(if_id_flush), 1);
    chk("C.id_ex_flush", 32'(id_ex_flush), 1);
    // the squashed writer of x6 must not be in slot 0
    cyc(); put(1, 6, 1, 0, 0, 0, 0, 0, 0);
    outs("C.bubble", 0, 0, 0, 3'b000, 3'b000);
    chk("C.cnt", stall_cnt, 0);

    // D: writer of x0 followed by a reader of x0
    do_reset();
    put(1, 1, 1, 2, 1, 1, 0, 0, 0);
    cyc(); put(1, 0, 1, 0, 1, 1, 7, 0, 0);
    outs("D.x0", 0, 0, 0, 3'b000, 3'b000);

    // E: reset pulsed during the second cycle of a dependency
    do_reset();
    put(1, 1, 1, 2, 1, 1, 5, 0, 0);
    cyc(); put(1, 5, 1, 5, 1, 1, 7, 0, 0);
`ifdef HZ_FWD_EN
    outs("E.c1", 0, 0, 0, 3'b001, 3'b001);
`else
    outs("E.c1", 1, 0, 1, 3'b000, 3'b000);
`endif
    cyc(); rst = 1'b1;
    outs("E.rst", 0, 0, 0, 3'b000, 3'b000);
    cyc(); rst = 1'b0;
    outs("E.after", 0, 0, 0, 3'b000, 3'b000);
    chk("E.cnt", stall_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard time limit so the bench always ends
  initial begin
    #100000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It keeps its own scoreboard of the instructions in flight between ID and writeback. It produces PC/IF-ID stalls, IF-ID/ID-EX flushes and per-operand forwarding selects. Control hazards resolved in EX take priority over data hazards. A saturating counter records the number of stall cycles.

## Interface
Parameters:
- `DEPTH`, 3: tracked stages after ID; slot 0 = EX … slot DEPTH-1 = WB. Legal range 2..8.
- `AW`, 5: register address width.
- `CNT_W`, 32: stall counter width.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  AW  source register addresses.
- `id_re1`, `id_re2`  in  1  source actually read (decoded by ID).
- `id_we`  in  1  ID instruction writes `id_rd`.
- `id_rd`  in  AW  destination register.
- `id_is_load`  in  1  ID instruction is a load.
- `ex_br_taken`  in  1  branch/jump in EX redirects the PC this cycle.
- `pc_stall`  out  1  hold PC.
- `if_id_stall`  out  1  hold the IF/ID register.
- `if_id_flush`  out  1  clear IF/ID to a bubble.
- `id_ex_flush`  out  1  load a bubble into ID/EX.
- `fwd_rs1_sel`, `fwd_rs2_sel`  out  DEPTH  one-hot forward source (bit k = slot k); all-zero = register file.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `pc_stall`=1.

## Operation
- Scoreboard: DEPTH registered slots, each holding {v, we, rd, ld}.
- Every cycle, slot[k+1] takes slot[k]; the entry leaving slot DEPTH-1 is dropped.
- Slot 0 takes the ID tag when `id_valid` & !stall & !`ex_br_taken`; otherwise slot 0 takes a bubble (v=0).
- Match(k, rs, re) = slot[k].v & slot[k].we & (slot[k].rd==rs) & (rs!=0) & re. Register x0 never hazards.
- When `id_valid`=0, all matches are forced low.
- Branch priority: if `ex_br_taken`=1, then `pc_stall`=0, `if_id_stall`=0, `if_id_flush`=1 and `id_ex_flush`=1. Any data stall is ignored in that cycle.
- Data stall (no branch): `pc_stall`=1, `if_id_stall`=1, `id_ex_flush`=1 and `if_id_flush`=0. The stall condition depends on the `HZ_FWD_EN` configuration.
- Forward select: the lowest-index matching slot wins and is one-hot. The select is forced to zero while stalling or while `id_valid`=0.
- `stall_cnt` increments at each edge where `pc_stall`=1. It holds at 2^CNT_W−1 and does not wrap.

## Timing
- All hazard and flush outputs are combinational from the current slots and the ID/EX inputs, with zero-cycle latency.
- The slots and `stall_cnt` update on the rising edge of `clk`.
- While `rst`=1, all outputs except `stall_cnt` are forced to 0 in the same cycle.
- At the first edge with `rst` high, all slots become invalid and `stall_cnt` becomes 0. After reset, `stall_cnt` reads 0.
- Reset asserted in the middle of a stall ends the stall immediately. No stale slot survives.
- A stall and a taken branch in the same cycle resolve as a flush only. The squashed ID instruction never enters slot 0.
- Back-to-back stalls re-evaluate every cycle. The stall releases in the first cycle in which the blocking slot no longer matches.
- With DEPTH=3, a load-use stall lasts exactly 1 cycle. The consumer then forwards from slot 1 (MEM).

## Configuration
- `HZ_FWD_EN` defined (forwarding datapath present):
  - Stall only when a matching slot 0 has ld=1 (load-use).
  - All other matches produce forward selects.
  - The WB slot must also be forwarded, because the register file is not write-through.
- `HZ_FWD_EN` undefined:
  - Stall on any match in any slot.
  - `fwd_rs1_sel` and `fwd_rs2_sel` are tied to 0.
  - A dependent instruction immediately behind its producer stalls DEPTH cycles.

## Test plan
- FWD_EN, `add x5` followed by `add x6,x5,x1` → no stall; `fwd_rs1_sel`=3'b001 in the consumer's ID cycle.
- FWD_EN, `lw x5` followed by `add x6,x0,x5` → `pc_stall`=1 for exactly 1 cycle, then `fwd_rs2_sel`=3'b010; `stall_cnt`=1.
- No FWD_EN, `add x5` followed by `sub x7,x5,x5` → `pc_stall`=1 for 3 consecutive cycles, then released; `stall_cnt`=3; selects always 0.
- Load-use stall with `ex_br_taken`=1 in the same cycle → `pc_stall`=0, `if_id_flush`=1, `id_ex_flush`=1; slot 0 is a bubble next cycle.
- Producer writes x0 (`id_rd`=0, `id_we`=1), consumer reads x0 → no stall, selects 0.
- `rst` pulsed during the second no-FWD stall cycle → all outputs 0 in that cycle; next cycle no stall; `stall_cnt`=0.
